sys_cmd_sequencer: RTL and testbench
====================================

// Module: sys_cmd_sequencer
// PURPOSE
//  Parametrised command sequencer between the UART RX/TX path, register file, ALU and TX FIFO.
//  Decodes framed host commands: write reg (0xAA), read reg (0xBB), ALU with operands (0xCC), ALU no-operand (0xDD).
//  Adds to the previous controller: registered outputs, multi-byte ALU result return, FIFO backpressure hold,
//  per-byte timeout, and error flagging of bad or unexpected frames.
// PARAMETERS
//  DATA_W      8     UART frame / regfile data width
//  ALU_W       16    ALU result width; must be an integer multiple of DATA_W
//  FUN_W       4     ALU function width, <= DATA_W
//  ADDR_W      4     regfile address width, <= DATA_W
//  OPA_ADDR    0     regfile address of operand A
//  OPB_ADDR    1     regfile address of operand B
//  TIMEOUT_CYC 1024  idle cycles allowed inside a command; 0 disables the timeout
// PORTS
//  clk         in   1       system clock
//  rst         in   1       asynchronous active-low reset
//  rx_p_data   in   DATA_W  received byte
//  rx_d_vld    in   1       rx_p_data valid, 1-cycle pulse per byte
//  rddata      in   DATA_W  regfile read data
//  rddata_vld  in   1       rddata valid
//  alu_out     in   ALU_W   ALU result
//  out_vld     in   1       alu_out valid
//  fifo_full   in   1       TX FIFO full
//  alu_fun     out  FUN_W   ALU function select
//  alu_en      out  1       ALU start, 1-cycle pulse
//  clk_en      out  1       ALU clock-gate enable
//  address     out  ADDR_W  regfile address
//  wr_data     out  DATA_W  regfile write data
//  wr_en       out  1       regfile write, 1-cycle pulse
//  rd_en       out  1       regfile read, 1-cycle pulse
//  tx_p_data   out  DATA_W  byte to TX FIFO
//  tx_d_vld    out  1       TX FIFO push, 1-cycle pulse
//  clk_div_en  out  1       clock divider enable
//  cmd_err     out  1       1-cycle pulse on bad opcode / timeout / stray byte
//  busy        out  1       high whenever state != IDLE
// BEHAVIOUR
//  - All outputs are registered. Reset: every output 0 except clk_div_en = 1 (constant 1).
//  - States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX.
//  - IDLE + rx_d_vld: latch the opcode. AA->WR_ADDR, BB->RD_ADDR, CC->OPA, DD->FUN.
//    Any other opcode: cmd_err pulse, stay in IDLE.
//  - WR_ADDR: byte latched as addr = rx_p_data[ADDR_W-1:0], -> WR_DATA.
//  - WR_DATA: byte -> next cycle wr_en=1, address=addr, wr_data=byte; -> IDLE.
//  - RD_ADDR: byte -> next cycle rd_en=1, address=byte[ADDR_W-1:0]; -> RD_WAIT.
//  - RD_WAIT: rddata_vld -> capture rddata as 1-byte result; -> TX.
//  - OPA/OPB: byte -> next cycle wr_en=1, address=OPA_ADDR/OPB_ADDR, wr_data=byte; -> OPB / FUN.
//  - FUN: byte -> next cycle alu_fun=byte[FUN_W-1:0], alu_en=1; -> ALU_WAIT. alu_fun holds until the next FUN.
//  - ALU_WAIT: out_vld -> capture alu_out as ALU_W/DATA_W-byte result; -> TX.
//  - clk_en is 1 from entry to OPA/FUN until exit of ALU_WAIT, 0 otherwise.
//  - TX: each cycle with !fifo_full pushes the next byte (LSB byte first) with a tx_d_vld pulse.
//    While fifo_full: no push, byte and index are held, no data is lost. After the last byte -> IDLE.
//  - Timeout counter: cleared on every state change and every accepted byte; counts in all
//    non-IDLE states except TX. Reaching TIMEOUT_CYC -> cmd_err pulse, -> IDLE, no write or ALU issued.
//  - rx_d_vld in RD_WAIT/ALU_WAIT/TX: byte dropped, cmd_err pulse, state unchanged.
//  - Reset mid-command: return to IDLE immediately, all pulses deasserted, partial command discarded.
// TESTING
//  1 rx AA,05,3C -> one wr_en cycle with address=5, wr_data=3C; busy low after; cmd_err never set.
//  2 rx BB,07; rddata=A5 with rddata_vld -> rd_en address=7, then one tx_d_vld with tx_p_data=A5.
//  3 rx CC,12,34,00; alu_out=0x0046 with out_vld -> writes 12@0 and 34@1, alu_fun=0,
//    then TX bytes 46 then 00; clk_en high over OPA..ALU_WAIT only.
//  4 DD,02 with fifo_full held 10 cycles at TX -> no push while full, both bytes pushed in order after release.
//  5 rx 5E -> cmd_err pulse, stays IDLE. Rx AA,03 then silence for TIMEOUT_CYC -> cmd_err, IDLE, no wr_en.
//  6 Assert rst during OPB -> all outputs at reset values; next AA,01,FF executes normally.

Source files
------------

// File: rtl/sys_cmd_sequencer.sv
// ============================================================================
// sys_cmd_sequencer
// ----------------------------------------------------------------------------
// Command sequencer that sits between the UART RX/TX path, the register file,
// the ALU and the TX FIFO. It decodes framed host commands:
//   0xAA addr data        : register write
//   0xBB addr             : register read, the read byte is returned on TX
//   0xCC opa opb fun      : load operands A/B, run the ALU, return the result
//   0xDD fun              : run the ALU on the current operands, return result
// The ALU result is returned LSB byte first (ALU_W/DATA_W bytes). The TX push
// stalls while the FIFO is full. A per-byte idle timeout aborts stalled
// commands. Bad opcodes, timeouts and stray bytes raise cmd_err.
//
// Ports
//   clk, rst                 : clock, asynchronous active-low reset
//   rx_p_data / rx_d_vld     : received byte with a one-cycle valid pulse
//   rddata / rddata_vld      : register file read return
//   alu_out / out_vld        : ALU result return
//   fifo_full                : TX FIFO backpressure
//   alu_fun, alu_en, clk_en  : ALU function, start pulse, clock-gate enable
//   address, wr_data, wr_en, rd_en : register file access
//   tx_p_data / tx_d_vld     : byte pushed to the TX FIFO
//   clk_div_en               : clock divider enable (always 1 out of reset)
//   cmd_err                  : one-cycle error pulse
//   busy                     : high whenever a command is in progress
// All outputs are registered.
// ============================================================================
module sys_cmd_sequencer #(
    parameter int DATA_W      = 8,
    parameter int ALU_W       = 16,
    parameter int FUN_W       = 4,
    parameter int ADDR_W      = 4,
    parameter int OPA_ADDR    = 0,
    parameter int OPB_ADDR    = 1,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_p_data,
    input  logic              rx_d_vld,
    input  logic [DATA_W-1:0] rddata,
    input  logic              rddata_vld,
    input  logic [ALU_W-1:0]  alu_out,
    input  logic              out_vld,
    input  logic              fifo_full,
    output logic [FUN_W-1:0]  alu_fun,
    output logic              alu_en,
    output logic              clk_en,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              rd_en,
    output logic [DATA_W-1:0] tx_p_data,
    output logic              tx_d_vld,
    output logic              clk_div_en,
    output logic              cmd_err,
    output logic              busy
);

    localparam int NB = ALU_W / DATA_W;
    localparam int CW = $clog2(NB + 1);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    localparam logic [DATA_W-1:0] OP_WR  = DATA_W'(8'hAA);
    localparam logic [DATA_W-1:0] OP_RD  = DATA_W'(8'hBB);
    localparam logic [DATA_W-1:0] OP_ALU = DATA_W'(8'hCC);
    localparam logic [DATA_W-1:0] OP_FUN = DATA_W'(8'hDD);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_WR_ADDR  = 4'd1;
    localparam logic [3:0] ST_WR_DATA  = 4'd2;
    localparam logic [3:0] ST_RD_ADDR  = 4'd3;
    localparam logic [3:0] ST_RD_WAIT  = 4'd4;
    localparam logic [3:0] ST_OPA      = 4'd5;
    localparam logic [3:0] ST_OPB      = 4'd6;
    localparam logic [3:0] ST_FUN      = 4'd7;
    localparam logic [3:0] ST_ALU_WAIT = 4'd8;
    localparam logic [3:0] ST_TX       = 4'd9;

    logic [3:0]        state_r;
    logic [3:0]        state_nx_s;
    logic              err_s;
    logic              counting_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ALU_W-1:0]  res_r;
    logic [CW-1:0]     cnt_r;
    logic [TW-1:0]     tmo_r;

    logic [FUN_W-1:0]  alu_fun_r;
    logic              alu_en_r;
    logic              clk_en_r;
    logic [ADDR_W-1:0] address_r;
    logic [DATA_W-1:0] wr_data_r;
    logic              wr_en_r;
    logic              rd_en_r;
    logic [DATA_W-1:0] tx_p_data_r;
    logic              tx_d_vld_r;
    logic              clk_div_en_r;
    logic              cmd_err_r;
    logic              busy_r;

    // Next-state decode, error detection and idle timeout abort.
    always_comb begin
        state_nx_s = state_r;
        err_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_d_vld) begin
                    case (rx_p_data)
                        OP_WR:   state_nx_s = ST_WR_ADDR;
                        OP_RD:   state_nx_s = ST_RD_ADDR;
                        OP_ALU:  state_nx_s = ST_OPA;
                        OP_FUN:  state_nx_s = ST_FUN;
                        default: err_s = 1'b1;
                    endcase
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WR_ADDR: if (rx_d_vld) state_nx_s = ST_WR_DATA; else state_nx_s = state_r;
            ST_WR_DATA: if (rx_d_vld) state_nx_s = ST_IDLE;    else state_nx_s = state_r;
            ST_RD_ADDR: if (rx_d_vld) state_nx_s = ST_RD_WAIT; else state_nx_s = state_r;
            ST_OPA:     if (rx_d_vld) state_nx_s = ST_OPB;     else state_nx_s = state_r;
            ST_OPB:     if (rx_d_vld) state_nx_s = ST_FUN;     else state_nx_s = state_r;
            ST_FUN:     if (rx_d_vld) state_nx_s = ST_ALU_WAIT; else state_nx_s = state_r;
            ST_RD_WAIT: begin
                if (rddata_vld) state_nx_s = ST_TX; else state_nx_s = state_r;
                err_s = rx_d_vld;
            end
            ST_ALU_WAIT: begin
                if (out_vld) state_nx_s = ST_TX; else state_nx_s = state_r;
                err_s = rx_d_vld;
            end
            ST_TX: begin
                if (!fifo_full && (cnt_r == CW'(1))) state_nx_s = ST_IDLE;
                else state_nx_s = state_r;
                err_s = rx_d_vld;
            end
            default: state_nx_s = ST_IDLE;
        endcase

        counting_s = (state_r != ST_IDLE) && (state_r != ST_TX);
        // Every accepted byte moves the FSM, so "no state change" means an
        // idle cycle; the abort fires on the TIMEOUT_CYC-th such cycle.
        if ((TIMEOUT_CYC != 0) && counting_s && (state_nx_s == state_r) &&
            (tmo_r == TMO_LAST)) begin
            state_nx_s = ST_IDLE;
            err_s      = 1'b1;
        end else begin
            state_nx_s = state_nx_s;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            addr_r       <= {ADDR_W{1'b0}};
            res_r        <= {ALU_W{1'b0}};
            cnt_r        <= {CW{1'b0}};
            tmo_r        <= {TW{1'b0}};
            alu_fun_r    <= {FUN_W{1'b0}};
            alu_en_r     <= 1'b0;
            clk_en_r     <= 1'b0;
            address_r    <= {ADDR_W{1'b0}};
            wr_data_r    <= {DATA_W{1'b0}};
            wr_en_r      <= 1'b0;
            rd_en_r      <= 1'b0;
            tx_p_data_r  <= {DATA_W{1'b0}};
            tx_d_vld_r   <= 1'b0;
            clk_div_en_r <= 1'b1;
            cmd_err_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            wr_en_r      <= 1'b0;
            rd_en_r      <= 1'b0;
            alu_en_r     <= 1'b0;
            tx_d_vld_r   <= 1'b0;
            clk_div_en_r <= 1'b1;
            cmd_err_r    <= err_s;
            busy_r       <= (state_nx_s != ST_IDLE);
            clk_en_r     <= (state_nx_s == ST_OPA) || (state_nx_s == ST_OPB) ||
                            (state_nx_s == ST_FUN) || (state_nx_s == ST_ALU_WAIT);
            if ((state_nx_s != state_r) || !counting_s) begin
                tmo_r <= {TW{1'b0}};
            end else begin
                tmo_r <= tmo_r + TW'(1);
            end

            // A timeout only fires on a cycle without an accepted byte, so
            // none of the byte-driven actions below can leak from an abort.
            case (state_r)
                ST_WR_ADDR: if (rx_d_vld) addr_r <= rx_p_data[ADDR_W-1:0];
                ST_WR_DATA: if (rx_d_vld) begin
                    wr_en_r   <= 1'b1;
                    address_r <= addr_r;
                    wr_data_r <= rx_p_data;
                end
                ST_RD_ADDR: if (rx_d_vld) begin
                    rd_en_r   <= 1'b1;
                    address_r <= rx_p_data[ADDR_W-1:0];
                end
                ST_RD_WAIT: if (rddata_vld) begin
                    res_r <= ALU_W'(rddata);
                    cnt_r <= CW'(1);
                end
                ST_OPA: if (rx_d_vld) begin
                    wr_en_r   <= 1'b1;
                    address_r <= ADDR_W'(OPA_ADDR);
                    wr_data_r <= rx_p_data;
                end
                ST_OPB: if (rx_d_vld) begin
                    wr_en_r   <= 1'b1;
                    address_r <= ADDR_W'(OPB_ADDR);
                    wr_data_r <= rx_p_data;
                end
                ST_FUN: if (rx_d_vld) begin
                    alu_fun_r <= rx_p_data[FUN_W-1:0];
                    alu_en_r  <= 1'b1;
                end
                ST_ALU_WAIT: if (out_vld) begin
                    res_r <= alu_out;
                    cnt_r <= CW'(NB);
                end
                // The result shifts down one byte per push, so a full FIFO
                // simply freezes the byte and the remaining count.
                ST_TX: if (!fifo_full) begin
                    tx_p_data_r <= res_r[DATA_W-1:0];
                    tx_d_vld_r  <= 1'b1;
                    res_r       <= res_r >> DATA_W;
                    cnt_r       <= cnt_r - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign alu_fun    = alu_fun_r;
    assign alu_en     = alu_en_r;
    assign clk_en     = clk_en_r;
    assign address    = address_r;
    assign wr_data    = wr_data_r;
    assign wr_en      = wr_en_r;
    assign rd_en      = rd_en_r;
    assign tx_p_data  = tx_p_data_r;
    assign tx_d_vld   = tx_d_vld_r;
    assign clk_div_en = clk_div_en_r;
    assign cmd_err    = cmd_err_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_sys_cmd_sequencer.sv
module tb_sys_cmd_sequencer;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_p_data;
    logic        rx_d_vld;
    logic [7:0]  rddata;
    logic        rddata_vld;
    logic [15:0] alu_out;
    logic        out_vld;
    logic        fifo_full;
    logic [3:0]  alu_fun;
    logic        alu_en;
    logic        clk_en;
    logic [3:0]  address;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  tx_p_data;
    logic        tx_d_vld;
    logic        clk_div_en;
    logic        cmd_err;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int err_cnt = 0;
    logic [7:0] tx_q[$];

    sys_cmd_sequencer dut (
        .clk(clk), .rst(rst),
        .rx_p_data(rx_p_data), .rx_d_vld(rx_d_vld),
        .rddata(rddata), .rddata_vld(rddata_vld),
        .alu_out(alu_out), .out_vld(out_vld),
        .fifo_full(fifo_full),
        .alu_fun(alu_fun), .alu_en(alu_en), .clk_en(clk_en),
        .address(address), .wr_data(wr_data), .wr_en(wr_en), .rd_en(rd_en),
        .tx_p_data(tx_p_data), .tx_d_vld(tx_d_vld),
        .clk_div_en(clk_div_en), .cmd_err(cmd_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            if (wr_en) wr_cnt = wr_cnt + 1;
            if (cmd_err) err_cnt = err_cnt + 1;
            if (tx_d_vld) tx_q.push_back(tx_p_data);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_p_data = b;
        rx_d_vld  = 1'b1;
        @(negedge clk);
        rx_d_vld  = 1'b0;
    endtask

    task automatic clear_mon();
        wr_cnt  = 0;
        err_cnt = 0;
        tx_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (clk_div_en !== 1'b1) begin errors++; $display("FAIL reset_clk_div_en: got %b want 1", clk_div_en); end
        checks++; if ({alu_fun, alu_en, clk_en, address, wr_data, wr_en, rd_en, tx_p_data, tx_d_vld, cmd_err, busy} !== 35'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", {alu_fun, alu_en, clk_en, address, wr_data, wr_en, rd_en, tx_p_data, tx_d_vld, cmd_err, busy});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        clear_mon();
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL wr_en: got %b want 1", wr_en); end
        checks++; if (address !== 4'h5) begin errors++; $display("FAIL wr_address: got %h want 5", address); end
        checks++; if (wr_data !== 8'h3C) begin errors++; $display("FAIL wr_data: got %h want 3c", wr_data); end
        repeat (3) @(negedge clk);
        checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL wr_count: got %0d want 1", wr_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy: got %b want 0", busy); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL wr_cmd_err: got %0d want 0", err_cnt); end
    endtask

    task automatic test_read();
        clear_mon();
        send_byte(8'hBB); send_byte(8'h07);
        checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL rd_en: got %b want 1", rd_en); end
        checks++; if (address !== 4'h7) begin errors++; $display("FAIL rd_address: got %h want 7", address); end
        rddata = 8'hA5; rddata_vld = 1'b1;
        @(negedge clk);
        rddata_vld = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (tx_q.size() !== 1) begin errors++; $display("FAIL rd_tx_count: got %0d want 1", tx_q.size()); end
        else begin
            checks++; if (tx_q[0] !== 8'hA5) begin errors++; $display("FAIL rd_tx_byte: got %h want a5", tx_q[0]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy: got %b want 0", busy); end
    endtask

    task automatic test_alu_ops();
        clear_mon();
        checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL alu_clk_en_idle: got %b want 0", clk_en); end
        send_byte(8'hCC);
        checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL alu_clk_en_opa: got %b want 1", clk_en); end
        send_byte(8'h12);
        checks++; if ({wr_en, address, wr_data} !== {1'b1, 4'h0, 8'h12}) begin errors++; $display("FAIL alu_opa_write: got %h want 1012", {wr_en, address, wr_data}); end
        send_byte(8'h34);
        checks++; if ({wr_en, address, wr_data} !== {1'b1, 4'h1, 8'h34}) begin errors++; $display("FAIL alu_opb_write: got %h want 1134", {wr_en, address, wr_data}); end
        send_byte(8'h00);
        checks++; if ({alu_en, alu_fun, clk_en} !== {1'b1, 4'h0, 1'b1}) begin errors++; $display("FAIL alu_start: got %h want 21", {alu_en, alu_fun, clk_en}); end
        alu_out = 16'h0046; out_vld = 1'b1;
        @(negedge clk);
        out_vld = 1'b0;
        checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL alu_clk_en_tx: got %b want 0", clk_en); end
        repeat (5) @(negedge clk);
        checks++; if (tx_q.size() !== 2) begin errors++; $display("FAIL alu_tx_count: got %0d want 2", tx_q.size()); end
        else begin
            checks++; if ({tx_q[0], tx_q[1]} !== 16'h4600) begin errors++; $display("FAIL alu_tx_bytes: got %h want 4600", {tx_q[0], tx_q[1]}); end
        end
        checks++; if (wr_cnt !== 2) begin errors++; $display("FAIL alu_wr_count: got %0d want 2", wr_cnt); end
    endtask

    task automatic test_backpressure();
        clear_mon();
        fifo_full = 1'b1;
        send_byte(8'hDD); send_byte(8'h02);
        checks++; if ({alu_en, alu_fun} !== {1'b1, 4'h2}) begin errors++; $display("FAIL bp_start: got %h want 12", {alu_en, alu_fun}); end
        alu_out = 16'hBEEF; out_vld = 1'b1;
        @(negedge clk);
        out_vld = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (tx_q.size() !== 0) begin errors++; $display("FAIL bp_push_while_full: got %0d want 0", tx_q.size()); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy_held: got %b want 1", busy); end
        fifo_full = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (tx_q.size() !== 2) begin errors++; $display("FAIL bp_tx_count: got %0d want 2", tx_q.size()); end
        else begin
            checks++; if ({tx_q[0], tx_q[1]} !== 16'hEFBE) begin errors++; $display("FAIL bp_tx_bytes: got %h want efbe", {tx_q[0], tx_q[1]}); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_errors();
        clear_mon();
        send_byte(8'h5E);
        checks++; if ({cmd_err, busy} !== 2'b10) begin errors++; $display("FAIL bad_opcode: got %b want 10", {cmd_err, busy}); end
        send_byte(8'hBB); send_byte(8'h02);
        send_byte(8'h77);
        checks++; if ({cmd_err, busy} !== 2'b11) begin errors++; $display("FAIL stray_byte: got %b want 11", {cmd_err, busy}); end
        rddata = 8'h3C; rddata_vld = 1'b1;
        @(negedge clk);
        rddata_vld = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (tx_q.size() !== 1) begin errors++; $display("FAIL stray_tx_count: got %0d want 1", tx_q.size()); end
        else begin
            checks++; if (tx_q[0] !== 8'h3C) begin errors++; $display("FAIL stray_tx_byte: got %h want 3c", tx_q[0]); end
        end
        checks++; if (err_cnt !== 2) begin errors++; $display("FAIL err_count: got %0d want 2", err_cnt); end
    endtask

    task automatic test_timeout();
        int waited;
        bit seen;
        clear_mon();
        seen = 1'b0;
        waited = 0;
        send_byte(8'hAA); send_byte(8'h03);
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            waited = i;
            if (cmd_err) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL timeout_seen: got 0 want 1 within 2000 cycles"); end
        checks++; if (waited < 1000 || waited > 1100) begin errors++; $display("FAIL timeout_delay: got %0d want about 1023", waited); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b want 0", busy); end
        repeat (2) @(negedge clk);
        checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL timeout_no_write: got %0d want 0", wr_cnt); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        send_byte(8'hCC); send_byte(8'h11);
        rst = 1'b0;
        #1;
        checks++; if ({clk_en, busy, wr_en, address, wr_data, alu_fun, clk_div_en} !== {3'b000, 4'h0, 8'h00, 4'h0, 1'b1}) begin
            errors++; $display("FAIL mid_reset_outputs: got %h want 1", {clk_en, busy, wr_en, address, wr_data, alu_fun, clk_div_en});
        end
        @(negedge clk);
        rst = 1'b1;
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF);
        checks++; if ({wr_en, address, wr_data} !== {1'b1, 4'h1, 8'hFF}) begin errors++; $display("FAIL post_reset_write: got %h want 11ff", {wr_en, address, wr_data}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    initial begin
        rst = 1'b0; rx_p_data = 8'h00; rx_d_vld = 1'b0;
        rddata = 8'h00; rddata_vld = 1'b0;
        alu_out = 16'h0000; out_vld = 1'b0; fifo_full = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_alu_ops();
        test_backpressure();
        test_errors();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
